// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter for four requesters sharing one port through a 4:1 mux.
// A grant is held until done, abandonment, or timeout, and is always followed by one idle cycle.
module rr_mux_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] req_i,
   input  logic       done_i,
   output logic [3:0] grant_o,
   output logic [1:0] select_o,
   output logic       busy_o,
   output logic       timeout_o
);
   typedef enum logic {IDLE, GRANT} state_e;
   state_e           state_q, state_d;
   logic [3:0]       grant_q, grant_d;
   logic [1:0]       sel_q, sel_d, last_q, last_d, win;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d, expired;
   // Scan from the farthest candidate back to the nearest so the first hit after last_q wins.
   always_comb begin
      win = '0;
      for (int i = 4; i >= 1; i--)
         if (req_i[2'(last_q + 2'(i))]) win = 2'(last_q + 2'(i));
   end
   assign expired = cnt_q == CNT_W'(TIMEOUT);
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      to_d    = 1'b0;
      if (state_q == IDLE) begin
         if (|req_i) begin
            state_d = GRANT;
            grant_d = 4'b0001 << win;
            sel_d   = win;
            cnt_d   = CNT_W'(1);
         end
      end else if (done_i || !req_i[sel_q] || expired) begin
         state_d = IDLE;
         grant_d = '0;
         last_d  = sel_q;
         cnt_d   = '0;
         to_d    = !done_i && expired;
      end else begin
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         last_q  <= 2'd3;
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end
   assign grant_o   = grant_q;
   assign select_o  = sel_q;
   assign busy_o    = |grant_q;
   assign timeout_o = to_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: vector table plus hand sequences for rr_mux_arbiter with TIMEOUT=4.
module tb_rr_mux_arbiter;
   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic [3:0] req_i = '0;
   logic       done_i = 1'b0;
   logic [3:0] grant_o;
   logic [1:0] select_o;
   logic       busy_o, timeout_o;
   int         n_chk = 0, n_fail = 0;
   always #5 clk_i = ~clk_i;
   rr_mux_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .done_i(done_i),
      .grant_o(grant_o), .select_o(select_o), .busy_o(busy_o), .timeout_o(timeout_o)
   );
   typedef struct packed {
      logic [3:0] req;
      logic       done;
      logic [3:0] g;
      logic [1:0] s;
      logic       b;
      logic       t;
   } vec_t;
   vec_t       tbl[33];
   logic [7:0] exp_q[$];
   task automatic check(input string name, input logic [7:0] exp);
      n_chk++;
      if ({grant_o, select_o, busy_o, timeout_o} !== exp) begin
         n_fail++;
         $display("FAIL %s: got grant=%b sel=%0d busy=%b to=%b, want grant=%b sel=%0d busy=%b to=%b",
                  name, grant_o, select_o, busy_o, timeout_o, exp[7:4], exp[3:2], exp[1], exp[0]);
      end
   endtask
   initial begin
      // single requester, done in first grant cycle
      tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
      tbl[1]  = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
      // all requesting, done in each grant's second cycle
      tbl[3]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[4]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
      tbl[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[7]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
      // after requester 2, 0101 wraps to requester 0
      tbl[9]  = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
      tbl[10] = '{4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[11] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[12] = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
      tbl[13] = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[14] = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
      tbl[15] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
      tbl[16] = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
      tbl[17] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
      tbl[18] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
      // timeout: four grant cycles then a one-cycle pulse
      tbl[19] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[20] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[21] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[22] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[23] = '{4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1};
      // re-grant to 1; done arrives exactly when counter==TIMEOUT
      tbl[24] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[25] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[26] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[27] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      tbl[28] = '{4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
      // requester 3 abandons
      tbl[29] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
      tbl[30] = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
      // pointer at 3: requester 2 wins a lone request, then gets reset mid-grant
      tbl[31] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[32] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      repeat (2) @(posedge clk_i);
      #1 check("reset", 8'b0000_00_0_0);
      @(negedge clk_i) rst_i = 1'b1;
      for (int i = 0; i < 33; i++) begin
         @(negedge clk_i);
         req_i  = tbl[i].req;
         done_i = tbl[i].done;
         exp_q.push_back({tbl[i].g, tbl[i].s, tbl[i].b, tbl[i].t});
         @(posedge clk_i);
         #1 check($sformatf("vec%0d", i), exp_q.pop_front());
      end
      @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1 check("rst_mid", 8'b0000_00_0_0);
      @(posedge clk_i);
      #1 check("rst_held", 8'b0000_00_0_0);
      @(negedge clk_i);
      rst_i = 1'b1;
      req_i = 4'b1111;
      exp_q.push_back(8'b0001_00_1_0);
      @(posedge clk_i);
      #1 check("post_rst", exp_q.pop_front());
      @(negedge clk_i) done_i = 1'b1;
      exp_q.push_back(8'b0000_00_0_0);
      @(posedge clk_i);
      #1 check("post_rst_done", exp_q.pop_front());
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
